// File: rtl/vgaterm_writer.sv
// vgaterm_writer: character-stream front end for the vgaterm text framebuffer.
// Accepts bytes over a valid/ready stream, keeps the cursor, decodes CR/LF/BS/FF,
// and sequences every cell write through vgaterm's writereq/writeack handshake.
// Optional feature macro: VGATERM_WRITER_TAB_EN (0x09 advances to the next tab stop
// by blanking cells; when undefined 0x09 is ignored like any unlisted control code).
module vgaterm_writer #(
    parameter int         COLS  = 100,
    parameter int         ROWS  = 32,
    parameter int         XBITS = 7,
    parameter int         YBITS = 5,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_char,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [XBITS-1:0] xwrite,
    output logic [YBITS-1:0] ywrite,
    output logic [7:0]       charout,
    output logic             writereq,
    input  logic             writeack,
    output logic [XBITS-1:0] curx,
    output logic [YBITS-1:0] cury,
    output logic             busy
);

    localparam logic [2:0] S_SYNC   = 3'd0;
    localparam logic [2:0] S_IDLE   = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_REQ    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    // What the current handshake belongs to; decides what happens after DONE.
    localparam logic [2:0] M_CHAR   = 3'd0;
    localparam logic [2:0] M_BS     = 3'd1;
    localparam logic [2:0] M_CLRROW = 3'd2;
    localparam logic [2:0] M_CLRALL = 3'd3;
`ifdef VGATERM_WRITER_TAB_EN
    localparam logic [2:0] M_TAB    = 3'd4;
    localparam logic [XBITS:0] COLS_W = (XBITS+1)'(COLS);
`endif

    localparam logic [XBITS-1:0] LAST_X = XBITS'(COLS - 1);
    localparam logic [YBITS-1:0] LAST_Y = YBITS'(ROWS - 1);

    logic [2:0]       r_state;
    logic [2:0]       r_mode;
    logic [7:0]       r_char;
    logic [XBITS-1:0] r_xwrite;
    logic [YBITS-1:0] r_ywrite;
    logic [7:0]       r_charout;
    logic [XBITS-1:0] r_curx;
    logic [YBITS-1:0] r_cury;

    logic             w_printable;
    logic [YBITS-1:0] w_next_y;
`ifdef VGATERM_WRITER_TAB_EN
    logic [XBITS:0]   r_tabstop;
    logic [XBITS:0]   w_tabstop;
    logic [XBITS-1:0] w_tab_end;

    // Next multiple of 8 above the cursor, and the last cell the tab blanks.
    assign w_tabstop = {1'b0, r_curx | XBITS'(7)} + (XBITS+1)'(1);
    assign w_tab_end = (r_tabstop >= COLS_W) ? LAST_X : XBITS'(r_tabstop - (XBITS+1)'(1));
`endif

    assign w_printable = (r_char >= 8'h20) && (r_char <= 8'h7E);
    assign w_next_y    = (r_cury == LAST_Y) ? '0 : r_cury + YBITS'(1);

    assign in_ready = (r_state == S_IDLE);
    assign busy     = (r_state != S_IDLE);
    assign writereq = (r_state == S_REQ);
    assign xwrite   = r_xwrite;
    assign ywrite   = r_ywrite;
    assign charout  = r_charout;
    assign curx     = r_curx;
    assign cury     = r_cury;

    // Latch the accepted byte; in_char is only sampled on an accepting edge.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && in_valid)
            r_char <= in_char;
    end

    // Main sequencer: sync to vgaterm, decode, and run one handshake per cell.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_SYNC;
            r_mode    <= M_CHAR;
            r_curx    <= '0;
            r_cury    <= '0;
            r_xwrite  <= '0;
            r_ywrite  <= '0;
            r_charout <= BLANK;
        end else begin
            case (r_state)
                // vgaterm has no reset and may still be finishing a write.
                S_SYNC: if (!writeack) r_state <= S_IDLE;
                S_IDLE: if (in_valid) r_state <= S_DECODE;
                S_DECODE: begin
                    if (w_printable) begin
                        r_xwrite  <= r_curx;
                        r_ywrite  <= r_cury;
                        r_charout <= r_char;
                        r_mode    <= M_CHAR;
                        r_state   <= S_REQ;
                    end else begin
                        case (r_char)
                            8'h0D: begin
                                r_curx  <= '0;
                                r_state <= S_IDLE;
                            end
                            // Cursor moves now so it holds its final value during the clear.
                            8'h0A: begin
                                r_cury    <= w_next_y;
                                r_xwrite  <= '0;
                                r_ywrite  <= w_next_y;
                                r_charout <= BLANK;
                                r_mode    <= M_CLRROW;
                                r_state   <= S_REQ;
                            end
                            8'h08: begin
                                if (r_curx != '0) begin
                                    r_xwrite  <= r_curx - XBITS'(1);
                                    r_ywrite  <= r_cury;
                                    r_charout <= BLANK;
                                    r_mode    <= M_BS;
                                    r_state   <= S_REQ;
                                end else begin
                                    r_state <= S_IDLE;
                                end
                            end
                            8'h0C: begin
                                r_xwrite  <= '0;
                                r_ywrite  <= '0;
                                r_charout <= BLANK;
                                r_mode    <= M_CLRALL;
                                r_state   <= S_REQ;
                            end
`ifdef VGATERM_WRITER_TAB_EN
                            8'h09: begin
                                r_xwrite  <= r_curx;
                                r_ywrite  <= r_cury;
                                r_charout <= BLANK;
                                r_tabstop <= w_tabstop;
                                r_mode    <= M_TAB;
                                r_state   <= S_REQ;
                            end
`endif
                            default: r_state <= S_IDLE;
                        endcase
                    end
                end
                S_REQ: if (writeack) r_state <= S_DONE;
                // writereq is already low here; wait for vgaterm to release ack.
                S_DONE: begin
                    if (!writeack) begin
                        case (r_mode)
                            M_CHAR: begin
                                if (r_curx == LAST_X) begin
                                    r_curx    <= '0;
                                    r_cury    <= w_next_y;
                                    r_xwrite  <= '0;
                                    r_ywrite  <= w_next_y;
                                    r_charout <= BLANK;
                                    r_mode    <= M_CLRROW;
                                    r_state   <= S_REQ;
                                end else begin
                                    r_curx  <= r_curx + XBITS'(1);
                                    r_state <= S_IDLE;
                                end
                            end
                            M_BS: begin
                                r_curx  <= r_xwrite;
                                r_state <= S_IDLE;
                            end
                            M_CLRROW: begin
                                if (r_xwrite == LAST_X) begin
                                    r_state <= S_IDLE;
                                end else begin
                                    r_xwrite <= r_xwrite + XBITS'(1);
                                    r_state  <= S_REQ;
                                end
                            end
                            M_CLRALL: begin
                                if (r_xwrite != LAST_X) begin
                                    r_xwrite <= r_xwrite + XBITS'(1);
                                    r_state  <= S_REQ;
                                end else if (r_ywrite != LAST_Y) begin
                                    r_xwrite <= '0;
                                    r_ywrite <= r_ywrite + YBITS'(1);
                                    r_state  <= S_REQ;
                                end else begin
                                    r_curx  <= '0;
                                    r_cury  <= '0;
                                    r_state <= S_IDLE;
                                end
                            end
`ifdef VGATERM_WRITER_TAB_EN
                            // Past the last tab stop the tab behaves like a printable wrap.
                            M_TAB: begin
                                if (r_xwrite != w_tab_end) begin
                                    r_xwrite <= r_xwrite + XBITS'(1);
                                    r_state  <= S_REQ;
                                end else if (r_tabstop >= COLS_W) begin
                                    r_curx    <= '0;
                                    r_cury    <= w_next_y;
                                    r_xwrite  <= '0;
                                    r_ywrite  <= w_next_y;
                                    r_charout <= BLANK;
                                    r_mode    <= M_CLRROW;
                                    r_state   <= S_REQ;
                                end else begin
                                    r_curx  <= r_tabstop[XBITS-1:0];
                                    r_state <= S_IDLE;
                                end
                            end
`endif
                            default: r_state <= S_IDLE;
                        endcase
                    end
                end
                default: r_state <= S_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_vgaterm_writer.sv
// Directed self-checking bench for vgaterm_writer (default build, tab feature off).
// A small vgaterm model acks each request after a programmable delay, logs every
// cell write and flags handshake/stability violations.
module tb_vgaterm_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_char;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] xwrite;
    logic [4:0] ywrite;
    logic [7:0] charout;
    logic       writereq;
    logic       writeack;
    logic [6:0] curx;
    logic [4:0] cury;
    logic       busy;

    logic force_ack;
    logic m_ack = 1'b0;
    assign writeack = force_ack | m_ack;

    int checks = 0;
    int errors = 0;

    // vgaterm model state
    int req_lat  = 2;
    int hold_lat = 3;
    int req_cnt  = 0;
    int hold_cnt = 0;
    int wr_cnt   = 0;
    int viol     = 0;
    logic       prev_req = 1'b0;
    logic       tracking = 1'b0;
    logic [6:0] tx;
    logic [4:0] ty;
    logic [7:0] tc;
    logic [6:0] log_x [4096];
    logic [4:0] log_y [4096];
    logic [7:0] log_c [4096];

    always #5 clk = ~clk;

    vgaterm_writer dut (
        .clk      (clk),
        .rst      (rst),
        .in_char  (in_char),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .xwrite   (xwrite),
        .ywrite   (ywrite),
        .charout  (charout),
        .writereq (writereq),
        .writeack (writeack),
        .curx     (curx),
        .cury     (cury),
        .busy     (busy)
    );

    // vgaterm model: ack req_lat cycles after req, drop hold_lat cycles later.
    always @(posedge clk) begin
        prev_req <= writereq;
        if (rst)
            tracking <= 1'b0;
        else if (writereq && !prev_req) begin
            tracking <= 1'b1;
            tx <= xwrite;
            ty <= ywrite;
            tc <= charout;
        end else if (tracking && (xwrite !== tx || ywrite !== ty || charout !== tc))
            viol <= viol + 1;
        if (m_ack) begin
            if (hold_cnt >= hold_lat - 1) begin
                m_ack    <= 1'b0;
                hold_cnt <= 0;
                tracking <= 1'b0;
                if (writereq) viol <= viol + 1;
            end else begin
                hold_cnt <= hold_cnt + 1;
            end
        end else if (writereq) begin
            if (req_cnt >= req_lat - 1) begin
                m_ack   <= 1'b1;
                req_cnt <= 0;
                log_x[wr_cnt & 4095] <= xwrite;
                log_y[wr_cnt & 4095] <= ywrite;
                log_c[wr_cnt & 4095] <= charout;
                wr_cnt  <= wr_cnt + 1;
            end else begin
                req_cnt <= req_cnt + 1;
            end
        end else begin
            req_cnt <= 0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        while (!in_ready) begin
            tick;
            n++;
            if (n > 30000) begin
                $display("FAIL send_byte timeout in_ready=%0b need 1", in_ready);
                $fatal(1, "timeout");
            end
        end
        in_char  = b;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy) begin
            tick;
            n++;
            if (n > budget) begin
                $display("FAIL wait_idle timeout busy=%0b need 0", busy);
                $fatal(1, "timeout");
            end
        end
    endtask

    task automatic test_reset;
        int bad;
        rst = 1'b1;
        force_ack = 1'b1;
        tick;
        tick;
        checks++;
        if ({writereq, in_ready, busy} !== 3'b001) begin
            errors++;
            $display("FAIL reset_ctrl req/rdy/busy=%b need 001", {writereq, in_ready, busy});
        end
        checks++;
        if ({curx, cury} !== 12'd0) begin
            errors++;
            $display("FAIL reset_cursor got %0d,%0d need 0,0", curx, cury);
        end
        checks++;
        if ({xwrite, ywrite} !== 12'd0 || charout !== 8'h20) begin
            errors++;
            $display("FAIL reset_wport got %0d,%0d,%h need 0,0,20", xwrite, ywrite, charout);
        end
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (in_ready !== 1'b0 || writereq !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL sync_hold bad_cycles=%0d need 0", bad);
        end
        force_ack = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL sync_same_cycle in_ready=%0b need 0", in_ready);
        end
        tick;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL sync_release rdy/busy=%b%b need 10", in_ready, busy);
        end
    endtask

    task automatic test_char_a;
        int base, n;
        base = wr_cnt;
        send_byte(8'h41);
        // Offer another byte while busy; it must not be taken.
        in_char  = 8'h5A;
        in_valid = 1'b1;
        n = 0;
        while (writeack !== 1'b1 && n < 50) begin
            tick;
            n++;
        end
        in_valid = 1'b0;
        checks++;
        if (writeack !== 1'b1) begin
            errors++;
            $display("FAIL char_ack_seen writeack=%0b need 1", writeack);
        end
        tick;
        checks++;
        if (writereq !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL char_req_drop req/rdy=%b%b need 00", writereq, in_ready);
        end
        wait_idle(200);
        checks++;
        if (wr_cnt - base !== 1) begin
            errors++;
            $display("FAIL char_count got %0d need 1", wr_cnt - base);
        end
        checks++;
        if (log_x[base & 4095] !== 7'd0 || log_y[base & 4095] !== 5'd0 || log_c[base & 4095] !== 8'h41) begin
            errors++;
            $display("FAIL char_cell got %0d,%0d,%h need 0,0,41",
                     log_x[base & 4095], log_y[base & 4095], log_c[base & 4095]);
        end
        checks++;
        if (curx !== 7'd1 || cury !== 5'd0 || in_ready !== 1'b1 || writeack !== 1'b0) begin
            errors++;
            $display("FAIL char_cursor got %0d,%0d rdy=%0b need 1,0 rdy=1", curx, cury, in_ready);
        end
    endtask

    task automatic test_ignored;
        logic [7:0] codes [4];
        int base;
        codes[0] = 8'h01; codes[1] = 8'h7F; codes[2] = 8'h1F; codes[3] = 8'h09;
        base = wr_cnt;
        for (int i = 0; i < 4; i++) begin
            send_byte(codes[i]);
            tick;
            checks++;
            if (in_ready !== 1'b1 || curx !== 7'd1 || cury !== 5'd0) begin
                errors++;
                $display("FAIL ignore_%h rdy=%0b cur=%0d,%0d need 1 cur=1,0", codes[i], in_ready, curx, cury);
            end
        end
        checks++;
        if (wr_cnt !== base) begin
            errors++;
            $display("FAIL ignore_writes got %0d need 0", wr_cnt - base);
        end
        send_byte(8'h0D);
        tick;
        checks++;
        if (in_ready !== 1'b1 || curx !== 7'd0 || wr_cnt !== base) begin
            errors++;
            $display("FAIL cr rdy=%0b curx=%0d writes=%0d need 1,0,0", in_ready, curx, wr_cnt - base);
        end
    endtask

    task automatic test_row_fill;
        int base, bad;
        base = wr_cnt;
        for (int i = 0; i < 100; i++) send_byte(8'h20 + 8'(i % 95));
        wait_idle(5000);
        checks++;
        if (wr_cnt - base !== 200) begin
            errors++;
            $display("FAIL fill_count got %0d need 200", wr_cnt - base);
        end
        bad = 0;
        for (int i = 0; i < 100; i++)
            if (log_x[(base + i) & 4095] !== 7'(i) || log_y[(base + i) & 4095] !== 5'd0 ||
                log_c[(base + i) & 4095] !== 8'h20 + 8'(i % 95)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL fill_row0 bad_cells=%0d need 0", bad);
        end
        bad = 0;
        for (int i = 0; i < 100; i++)
            if (log_x[(base + 100 + i) & 4095] !== 7'(i) || log_y[(base + 100 + i) & 4095] !== 5'd1 ||
                log_c[(base + 100 + i) & 4095] !== 8'h20) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL fill_clr_row1 bad_cells=%0d need 0", bad);
        end
        checks++;
        if (curx !== 7'd0 || cury !== 5'd1) begin
            errors++;
            $display("FAIL fill_cursor got %0d,%0d need 0,1", curx, cury);
        end
    endtask

    task automatic test_lf_wrap;
        int base, bad;
        req_lat  = 1;
        hold_lat = 2;
        for (int i = 0; i < 30; i++) send_byte(8'h0A);
        wait_idle(5000);
        checks++;
        if (curx !== 7'd0 || cury !== 5'd31) begin
            errors++;
            $display("FAIL lf_walk got %0d,%0d need 0,31", curx, cury);
        end
        send_byte(8'h51);
        wait_idle(200);
        base = wr_cnt;
        send_byte(8'h0A);
        tick;
        checks++;
        if (curx !== 7'd1 || cury !== 5'd0 || writereq !== 1'b1) begin
            errors++;
            $display("FAIL lf_cursor_early got %0d,%0d req=%0b need 1,0 req=1", curx, cury, writereq);
        end
        wait_idle(5000);
        checks++;
        if (wr_cnt - base !== 100) begin
            errors++;
            $display("FAIL lf_count got %0d need 100", wr_cnt - base);
        end
        bad = 0;
        for (int i = 0; i < 100; i++)
            if (log_x[(base + i) & 4095] !== 7'(i) || log_y[(base + i) & 4095] !== 5'd0 ||
                log_c[(base + i) & 4095] !== 8'h20) bad++;
        checks++;
        if (bad !== 0 || curx !== 7'd1 || cury !== 5'd0) begin
            errors++;
            $display("FAIL lf_wrap_clear bad=%0d cur=%0d,%0d need 0 cur=1,0", bad, curx, cury);
        end
    endtask

    task automatic test_bs;
        int base;
        for (int i = 0; i < 4; i++) send_byte(8'h62 + 8'(i));
        wait_idle(200);
        base = wr_cnt;
        send_byte(8'h08);
        wait_idle(200);
        checks++;
        if (wr_cnt - base !== 1 || log_x[base & 4095] !== 7'd4 || log_y[base & 4095] !== 5'd0 ||
            log_c[base & 4095] !== 8'h20) begin
            errors++;
            $display("FAIL bs_write n=%0d cell=%0d,%0d,%h need 1 cell=4,0,20",
                     wr_cnt - base, log_x[base & 4095], log_y[base & 4095], log_c[base & 4095]);
        end
        checks++;
        if (curx !== 7'd4 || cury !== 5'd0) begin
            errors++;
            $display("FAIL bs_cursor got %0d,%0d need 4,0", curx, cury);
        end
        send_byte(8'h0D);
        wait_idle(20);
        base = wr_cnt;
        send_byte(8'h08);
        checks++;
        if (in_ready !== 1'b0 || writereq !== 1'b0) begin
            errors++;
            $display("FAIL bs_col0_decode rdy/req=%b%b need 00", in_ready, writereq);
        end
        tick;
        checks++;
        if (in_ready !== 1'b1 || writereq !== 1'b0 || wr_cnt !== base || curx !== 7'd0 || cury !== 5'd0) begin
            errors++;
            $display("FAIL bs_col0 rdy=%0b req=%0b n=%0d cur=%0d,%0d need 1,0,0 cur=0,0",
                     in_ready, writereq, wr_cnt - base, curx, cury);
        end
    endtask

    task automatic test_ff_full;
        int base, bad;
        send_byte(8'h78);
        send_byte(8'h79);
        send_byte(8'h0A);
        wait_idle(5000);
        base = wr_cnt;
        send_byte(8'h0C);
        wait_idle(20000);
        checks++;
        if (wr_cnt - base !== 3200) begin
            errors++;
            $display("FAIL ff_count got %0d need 3200", wr_cnt - base);
        end
        bad = 0;
        for (int i = 0; i < 3200; i++)
            if (log_x[(base + i) & 4095] !== 7'(i % 100) || log_y[(base + i) & 4095] !== 5'(i / 100) ||
                log_c[(base + i) & 4095] !== 8'h20) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL ff_cells bad_cells=%0d need 0", bad);
        end
        checks++;
        if (curx !== 7'd0 || cury !== 5'd0) begin
            errors++;
            $display("FAIL ff_cursor got %0d,%0d need 0,0", curx, cury);
        end
    endtask

    task automatic test_ff_reset;
        int base, n;
        req_lat  = 2;
        hold_lat = 3;
        send_byte(8'h6B);
        wait_idle(200);
        base = wr_cnt;
        send_byte(8'h0C);
        n = 0;
        while (wr_cnt - base < 1000) begin
            tick;
            n++;
            if (n > 20000) begin
                $display("FAIL ffrst_wait writes=%0d need 1000", wr_cnt - base);
                $fatal(1, "timeout");
            end
        end
        rst = 1'b1;
        tick;
        checks++;
        if (writereq !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0 || curx !== 7'd0) begin
            errors++;
            $display("FAIL ffrst_abort req=%0b busy=%0b rdy=%0b curx=%0d need 0,1,0,0",
                     writereq, busy, in_ready, curx);
        end
        rst = 1'b0;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            tick;
            n++;
        end
        checks++;
        if (in_ready !== 1'b1 || writeack !== 1'b0 || wr_cnt - base !== 1000) begin
            errors++;
            $display("FAIL ffrst_resync rdy=%0b ack=%0b writes=%0d need 1,0,1000",
                     in_ready, writeack, wr_cnt - base);
        end
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL handshake_violations got %0d need 0", viol);
        end
    endtask

    initial begin
        rst       = 1'b1;
        force_ack = 1'b1;
        in_valid  = 1'b0;
        in_char   = 8'h00;
        test_reset;
        test_char_a;
        test_ignored;
        test_row_fill;
        test_lf_wrap;
        test_bs;
        test_ff_full;
        test_ff_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
